serializer_link_sequencer: RTL and testbench
============================================

Name: serializer_link_sequencer

Overview:
- Pixel-clock controller that brings up the OSERDES-based TMDS serializer and sequences it.
- Waits for a stable MMCM lock, then holds the serializer in reset, enables it, and sends a blanking training period.
- After training, passes encoded TMDS words through to the serializer.
- Sits between the TMDS encoders and the serializer. Drives the serializer's RST/OCE and its 10-bit per-channel words.

Parameters:
- NUM_CHANNELS, 3, number of TMDS data channels.
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before bring-up (>=1).
- RST_CYCLES, 16, cycles serdes_rst is held high in RESET_SERDES (>=1).
- SETTLE_CYCLES, 8, cycles with rst low and oce low before output enable (>=1).
- TRAIN_CYCLES, 64, cycles of blanking word with oce high before RUN (>=1).
- BLANK_WORD, 10'b1101010100, control-period word (c1c0=00) sent when not in RUN.

Ports:
- clk_pixel  in  1  pixel clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw MMCM locked, asynchronous to clk_pixel.
- retrain  in  1  single-cycle request to re-run the bring-up from RESET_SERDES.
- tmds_in  in  NUM_CHANNELS x 10  encoded words from the encoders (unpacked array [NUM_CHANNELS-1:0]).
- tmds_out  out  NUM_CHANNELS x 10  words to the serializer.
- serdes_rst  out  1  serializer reset.
- serdes_oce  out  1  serializer output clock enable.
- ready  out  1  link in RUN.
- state  out  3  debug state code: WAIT_LOCK=0, RESET_SERDES=1, SETTLE=2, TRAIN=3, RUN=4.
- lock_loss_count  out  8  saturating count of lock losses seen outside WAIT_LOCK.

Behaviour:
- Lock synchronizer:
  - pll_locked passes through a 2-flop synchronizer to give locked_s.
  - Synchronizer flops reset to 0.
  - All decisions use locked_s only.
- Reset values: state=WAIT_LOCK, cnt=0, serdes_rst=1, serdes_oce=0, ready=0, all tmds_out channels=BLANK_WORD, lock_loss_count=0.
- Outputs: all outputs are registered and reflect the current state; no combinational paths from inputs.
- Counter: one shared counter cnt, wide enough for the largest parameter. It clears to 0 on every state transition.
- WAIT_LOCK:
  - Outputs: rst=1, oce=0, blank words.
  - cnt increments while locked_s=1 and clears when locked_s=0.
  - When locked_s=1 and cnt==LOCK_STABLE_CYCLES-1, go to RESET_SERDES.
- RESET_SERDES:
  - Outputs: rst=1, oce=0, blank words.
  - After RST_CYCLES cycles in the state, go to SETTLE.
- SETTLE:
  - Outputs: rst=0, oce=0, blank words.
  - After SETTLE_CYCLES cycles, go to TRAIN.
- TRAIN:
  - Outputs: rst=0, oce=1, blank words on every channel.
  - After TRAIN_CYCLES cycles, go to RUN.
- RUN:
  - Outputs: rst=0, oce=1, ready=1.
  - tmds_out[i] <= tmds_in[i] each cycle, i.e. 1-cycle latency.
  - The first RUN cycle already outputs tmds_in registered on the transition edge.
- Dwell times:
  - Each timed state lasts exactly its parameter's number of cycles.
  - From the first cycle locked_s=1, ready rises after LOCK_STABLE+RST+SETTLE+TRAIN cycles.
- Lock loss:
  - In any state other than WAIT_LOCK, locked_s=0 sends the block to WAIT_LOCK on the next edge.
  - The same edge sets rst=1, oce=0, ready=0, blank words, and increments lock_loss_count, saturating at 255.
  - Lock loss takes priority over retrain and over timer expiry.
- Retrain:
  - retrain=1 with locked_s=1 in SETTLE, TRAIN or RUN goes to RESET_SERDES.
  - retrain is ignored in WAIT_LOCK and RESET_SERDES; the counter is not restarted.
  - retrain does not change lock_loss_count.
- Lock glitch during WAIT_LOCK: any locked_s=0 clears cnt, so stability must restart from zero.
- Reset mid-operation: reset overrides everything and returns all state and outputs to their reset values on the same edge. The synchronizer also clears, so re-qualification takes 2 extra cycles.

Test Plan:
- Params L=4, R=2, S=2, T=3; pll_locked raised at cycle 0 and held.
  - Required: serdes_rst falls at cycle 2+4+2=8; oce rises at 10; ready rises at 13.
  - tmds_out = 1101010100 on all channels until cycle 13, then tmds_in delayed 1 cycle (drive 0x2AA/0x155/0x3FF and check).
- pll_locked pulsed low for 1 cycle at WAIT_LOCK cnt=3.
  - Required: cnt clears; ready rises 4+2+2+3 cycles after locked_s returns high.
- In RUN, drop pll_locked.
  - Required: 3 edges later (2 sync + 1) state=0, rst=1, oce=0, ready=0, blank words, lock_loss_count=1.
  - Repeat 300 times: lock_loss_count must saturate at 255.
- In RUN, pulse retrain.
  - Required: next edge state=1, rst=1, ready=0; RUN re-entered after exactly 2+2+3 cycles.
  - retrain pulsed in WAIT_LOCK: no effect.
- In TRAIN, assert retrain on the same cycle locked_s falls.
  - Required: state=WAIT_LOCK and lock_loss_count increments (lock loss wins).
- Assert reset for 1 cycle in RUN.
  - Required: all outputs at reset values next edge; lock_loss_count=0; full bring-up repeats with ready at 2+L+R+S+T cycles after reset release.

Source files
------------

// File: rtl/serializer_link_sequencer.sv
// TMDS serializer bring-up sequencer: lock qualification, serdes reset,
// settle, blanking training, then pass-through of encoded words.
//
// Ports:
//   clk_pixel        pixel clock, all logic on its rising edge
//   reset            synchronous active-high reset
//   pll_locked       raw MMCM lock (asynchronous, synchronized inside)
//   retrain          single-cycle request to restart from RESET_SERDES
//   tmds_in          per-channel encoded 10-bit words
//   tmds_out         per-channel words to the serializer (registered)
//   serdes_rst       serializer reset (registered)
//   serdes_oce       serializer output clock enable (registered)
//   ready            link is in RUN (registered)
//   state            debug state code
//   lock_loss_count  saturating count of lock losses outside WAIT_LOCK
module serializer_link_sequencer #(
   parameter int          NUM_CHANNELS       = 3,
   parameter int          LOCK_STABLE_CYCLES = 1024,
   parameter int          RST_CYCLES         = 16,
   parameter int          SETTLE_CYCLES      = 8,
   parameter int          TRAIN_CYCLES       = 64,
   parameter logic [9:0]  BLANK_WORD         = 10'b1101010100
) (
   input  logic       clk_pixel,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       retrain,
   input  logic [9:0] tmds_in [NUM_CHANNELS-1:0],
   output logic [9:0] tmds_out [NUM_CHANNELS-1:0],
   output logic       serdes_rst,
   output logic       serdes_oce,
   output logic       ready,
   output logic [2:0] state,
   output logic [7:0] lock_loss_count
);

   localparam int MAX_A = (LOCK_STABLE_CYCLES > RST_CYCLES) ?
                          LOCK_STABLE_CYCLES : RST_CYCLES;
   localparam int MAX_B = (SETTLE_CYCLES > TRAIN_CYCLES) ?
                          SETTLE_CYCLES : TRAIN_CYCLES;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_WAIT_LOCK    = 3'd0,
      ST_RESET_SERDES = 3'd1,
      ST_SETTLE       = 3'd2,
      ST_TRAIN        = 3'd3,
      ST_RUN          = 3'd4
   } state_t;

   logic [1:0]       sync_q, sync_d;
   logic             locked_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       llc_q, llc_d;
   logic             rst_q, rst_d;
   logic             oce_q, oce_d;
   logic             ready_q, ready_d;
   logic [9:0]       tmds_q [NUM_CHANNELS-1:0];
   logic [9:0]       tmds_d [NUM_CHANNELS-1:0];

   assign sync_d   = {sync_q[0], pll_locked};
   assign locked_s = sync_q[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      llc_d   = llc_q;
      unique case (state_q)
         ST_WAIT_LOCK: begin
            // Any dip in lock restarts the stability window.
            if (!locked_s) begin
               cnt_d = '0;
            end else if (cnt_q == L_LAST) begin
               state_d = ST_RESET_SERDES;
               cnt_d   = '0;
            end
         end
         ST_RESET_SERDES: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
               if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
            end else if (cnt_q == R_LAST) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end
         end
         ST_SETTLE, ST_TRAIN, ST_RUN: begin
            // Lock loss outranks retrain, which outranks timer expiry.
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
               if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
            end else if (retrain) begin
               state_d = ST_RESET_SERDES;
               cnt_d   = '0;
            end else if (state_q == ST_SETTLE && cnt_q == S_LAST) begin
               state_d = ST_TRAIN;
               cnt_d   = '0;
            end else if (state_q == ST_TRAIN && cnt_q == T_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (state_q == ST_RUN) begin
               cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so they are registered
      // together with it and always match the visible state.
      rst_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_RESET_SERDES);
      oce_d   = (state_d == ST_TRAIN) || (state_d == ST_RUN);
      ready_d = (state_d == ST_RUN);
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         tmds_d[i] = (state_d == ST_RUN) ? tmds_in[i] : BLANK_WORD;
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         sync_q  <= '0;
         state_q <= ST_WAIT_LOCK;
         cnt_q   <= '0;
         llc_q   <= '0;
         rst_q   <= 1'b1;
         oce_q   <= 1'b0;
         ready_q <= 1'b0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            tmds_q[i] <= BLANK_WORD;
         end
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         llc_q   <= llc_d;
         rst_q   <= rst_d;
         oce_q   <= oce_d;
         ready_q <= ready_d;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            tmds_q[i] <= tmds_d[i];
         end
      end
   end

   assign tmds_out        = tmds_q;
   assign serdes_rst      = rst_q;
   assign serdes_oce      = oce_q;
   assign ready           = ready_q;
   assign state           = state_q;
   assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_serializer_link_sequencer.sv
// Scoreboard bench for serializer_link_sequencer with short dwell times.
// Stimulus queues cycle-stamped expectations; a monitor checks them.
module tb_serializer_link_sequencer;

   localparam logic [9:0] BLANK = 10'b1101010100;

   logic       clk = 1'b0;
   logic       reset, pll_locked, retrain;
   logic [9:0] tmds_in  [2:0];
   logic [9:0] tmds_out [2:0];
   logic       serdes_rst, serdes_oce, ready;
   logic [2:0] state;
   logic [7:0] lock_loss_count;

   always #5 clk = ~clk;

   serializer_link_sequencer #(
      .NUM_CHANNELS(3), .LOCK_STABLE_CYCLES(4), .RST_CYCLES(2),
      .SETTLE_CYCLES(2), .TRAIN_CYCLES(3), .BLANK_WORD(10'b1101010100)
   ) dut (
      .clk_pixel(clk), .reset(reset), .pll_locked(pll_locked),
      .retrain(retrain), .tmds_in(tmds_in), .tmds_out(tmds_out),
      .serdes_rst(serdes_rst), .serdes_oce(serdes_oce), .ready(ready),
      .state(state), .lock_loss_count(lock_loss_count)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    cyc;
      int    sel;
      int    val;
      string name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic int actual(int sel);
      case (sel)
         0: return int'(state);
         1: return int'(serdes_rst);
         2: return int'(serdes_oce);
         3: return int'(ready);
         4: return int'(lock_loss_count);
         5: return int'(tmds_out[0]);
         6: return int'(tmds_out[1]);
         7: return int'(tmds_out[2]);
         default: return -1;
      endcase
   endfunction

   task automatic expect_at(int d, int sel, int val, string nm);
      exp_t e;
      e.cyc  = cyc + d;
      e.sel  = sel;
      e.val  = val;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic expect_blank(int d, string nm);
      expect_at(d, 5, int'(BLANK), {nm, "_ch0"});
      expect_at(d, 6, int'(BLANK), {nm, "_ch1"});
      expect_at(d, 7, int'(BLANK), {nm, "_ch2"});
   endtask

   task automatic expect_idle(int d, int llc, string nm);
      expect_at(d, 0, 0, {nm, "_state"});
      expect_at(d, 1, 1, {nm, "_rst"});
      expect_at(d, 2, 0, {nm, "_oce"});
      expect_at(d, 3, 0, {nm, "_ready"});
      expect_at(d, 4, llc, {nm, "_llc"});
      expect_blank(d, nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(int c);
      while (cyc < c) tick();
   endtask

   task automatic set_in(int a, int b, int c);
      tmds_in[0] = 10'(a);
      tmds_in[1] = 10'(b);
      tmds_in[2] = 10'(c);
   endtask

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      int a;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            n_checks++;
            a = actual(sb[i].sel);
            if (a == sb[i].val) n_pass++;
            else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                          sb[i].name, cyc, a, sb[i].val);
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            n_checks++;
            $display("FAIL %s cyc=%0d never sampled", sb[i].name, sb[i].cyc);
            sb.delete(i);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int b, c, g, r, w, x, exp_llc;
      reset      = 1'b1;
      pll_locked = 1'b0;
      retrain    = 1'b0;
      set_in(10'h0F0, 10'h0F0, 10'h0F0);
      tick(); tick(); tick();

      // Reset values, then bring-up with lock raised right at release.
      expect_idle(0, 0, "rst_vals");
      reset      = 1'b0;
      pll_locked = 1'b1;
      b = cyc;
      expect_at(5, 0, 0, "bu_wait5");
      expect_at(6, 0, 1, "bu_reset6");
      expect_at(7, 1, 1, "bu_rst7");
      expect_at(8, 1, 0, "bu_rst8");
      expect_at(9, 2, 0, "bu_oce9");
      expect_at(10, 2, 1, "bu_oce10");
      expect_at(12, 3, 0, "bu_ready12");
      expect_blank(12, "bu_blank12");
      expect_at(13, 3, 1, "bu_ready13");
      expect_at(13, 0, 4, "bu_run13");
      expect_at(13, 5, 10'h2AA, "run_a_ch0");
      expect_at(13, 6, 10'h155, "run_a_ch1");
      expect_at(13, 7, 10'h3FF, "run_a_ch2");
      expect_at(14, 5, 10'h155, "run_b_ch0");
      expect_at(14, 6, 10'h3FF, "run_b_ch1");
      expect_at(14, 7, 10'h2AA, "run_b_ch2");
      expect_at(15, 5, 10'h3FF, "run_c_ch0");
      expect_at(15, 6, 10'h2AA, "run_c_ch1");
      expect_at(15, 7, 10'h155, "run_c_ch2");
      run_to(b + 12); set_in(10'h2AA, 10'h155, 10'h3FF);
      tick();         set_in(10'h155, 10'h3FF, 10'h2AA);
      tick();         set_in(10'h3FF, 10'h2AA, 10'h155);
      run_to(b + 16);

      // Lock loss in RUN.
      c = cyc;
      pll_locked = 1'b0;
      expect_at(2, 0, 4, "loss_still_run");
      expect_idle(3, 1, "loss");
      run_to(c + 5);

      // Glitch during WAIT_LOCK at cnt=3 restarts qualification.
      g = cyc;
      pll_locked = 1'b1;
      expect_at(6, 0, 0, "glitch_wait6");
      expect_at(7, 0, 0, "glitch_wait7");
      expect_at(10, 0, 1, "glitch_reset10");
      expect_at(16, 3, 0, "glitch_ready16");
      expect_at(17, 3, 1, "glitch_ready17");
      run_to(g + 3); pll_locked = 1'b0;
      tick();        pll_locked = 1'b1;
      run_to(g + 18);

      // Retrain from RUN.
      r = cyc;
      retrain = 1'b1;
      expect_at(1, 0, 1, "rt_state");
      expect_at(1, 1, 1, "rt_rst");
      expect_at(1, 3, 0, "rt_ready");
      expect_at(1, 4, 1, "rt_llc");
      expect_at(7, 0, 3, "rt_train7");
      expect_at(8, 0, 4, "rt_run8");
      expect_at(8, 3, 1, "rt_ready8");
      tick(); retrain = 1'b0;
      run_to(r + 9);

      // Retrain and lock loss on the same edge in TRAIN: lock loss wins.
      r = cyc;
      retrain = 1'b1;
      expect_at(6, 0, 3, "both_train");
      expect_idle(7, 2, "both");
      tick(); retrain = 1'b0;
      run_to(r + 4); pll_locked = 1'b0;
      run_to(r + 6); retrain = 1'b1;
      tick();        retrain = 1'b0;
      run_to(r + 9);

      // Retrain in WAIT_LOCK is ignored, counter keeps going.
      w = cyc;
      pll_locked = 1'b1;
      expect_at(4, 0, 0, "wrt_wait4");
      expect_at(5, 0, 0, "wrt_wait5");
      expect_at(6, 0, 1, "wrt_reset6");
      expect_at(6, 4, 2, "wrt_llc");
      expect_at(13, 3, 1, "wrt_ready13");
      run_to(w + 3); retrain = 1'b1;
      tick();        retrain = 1'b0;
      run_to(w + 14);

      // Repeated lock losses saturate the counter.
      exp_llc = 2;
      for (int i = 0; i < 300; i++) begin
         c = cyc;
         pll_locked = 1'b0;
         if (exp_llc < 255) exp_llc++;
         expect_at(3, 0, 0, "sat_state");
         expect_at(3, 4, exp_llc, "sat_llc");
         run_to(c + 3);
         pll_locked = 1'b1;
         w = cyc;
         expect_at(6, 0, 1, "sat_reset");
         run_to(w + 6);
      end
      expect_at(7, 3, 1, "sat_run");
      expect_at(7, 4, 255, "sat_final_llc");
      run_to(cyc + 7);

      // Reset in RUN: immediate return to reset values, then full bring-up.
      x = cyc;
      reset = 1'b1;
      expect_idle(1, 0, "mid_rst");
      expect_at(6, 0, 0, "mid_wait6");
      expect_at(7, 0, 1, "mid_reset7");
      expect_at(13, 3, 0, "mid_ready13");
      expect_at(14, 3, 1, "mid_ready14");
      expect_at(14, 4, 0, "mid_llc14");
      tick(); reset = 1'b0;
      run_to(x + 17);

      foreach (sb[i]) begin
         n_checks++;
         $display("FAIL %s cyc=%0d left unchecked", sb[i].name, sb[i].cyc);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
